mult_array_pipe: RTL

MULT_ARRAY_PIPE -- requirements
Module: mult_array_pipe

---
 rtl/mult_array_pipe.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/mult_array_pipe.sv
// -----------------------------------------------------------------------------
// mult_array_pipe
//   INPUT_NUM parallel DATA_WIDTH x DATA_WIDTH multipliers behind a
//   valid/ready pipeline with one global advance enable. Each beat carries its
//   own sign_mode, so signed and unsigned beats can be mixed freely.
//
//   Stage A registers operands, sign_mode and valid. Stage B registers the
//   exact 2*DATA_WIDTH products. With MULT_ARRAY_PIPE_SUM_EN defined, stage C
//   registers the sum of all lane products together with a delayed copy of the
//   products. Latency is 2 cycles by default and 3 cycles with the sum enabled.
//
//   Optional feature macro: MULT_ARRAY_PIPE_SUM_EN (undefined: sum_data = 0).
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operand beat valid
//   in_ready     beat accepted this cycle (equals the advance enable)
//   sign_mode    1 = signed two's complement, 0 = unsigned (per beat)
//   input_data   lane i operand at [DATA_WIDTH*i +: DATA_WIDTH]
//   weight_data  lane i weight  at [DATA_WIDTH*i +: DATA_WIDTH]
//   out_valid    result beat valid
//   out_ready    downstream accepts the result
//   output_data  lane i product at [2*DATA_WIDTH*i +: 2*DATA_WIDTH]
//   sum_data     sum of all lane products (0 when the sum stage is absent)
//   busy         any pipeline stage holds a valid beat
// -----------------------------------------------------------------------------
module mult_array_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_NUM  = 6,
  localparam int PROD_WIDTH = 2 * DATA_WIDTH,
  localparam int SUM_WIDTH  = (INPUT_NUM == 1) ? 2 * DATA_WIDTH
                                               : 2 * DATA_WIDTH + $clog2(INPUT_NUM)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sign_mode,
  input  logic [DATA_WIDTH*INPUT_NUM-1:0] input_data,
  input  logic [DATA_WIDTH*INPUT_NUM-1:0] weight_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PROD_WIDTH*INPUT_NUM-1:0] output_data,
  output logic [SUM_WIDTH-1:0]            sum_data,
  output logic                            busy
);

  localparam int OPS_W = DATA_WIDTH * INPUT_NUM;
  localparam int OUT_W = PROD_WIDTH * INPUT_NUM;

  // Extending both operands to the full product width and keeping the low
  // PROD_WIDTH bits of their product gives the exact result for either mode.
  function automatic logic [PROD_WIDTH-1:0] ext_operand(input logic [DATA_WIDTH-1:0] v,
                                                        input logic sgn);
    logic [PROD_WIDTH-1:0] r;
    if (sgn) begin
      r = {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
    end else begin
      r = {{DATA_WIDTH{1'b0}}, v};
    end
    return r;
  endfunction

  logic                  en_s;
  logic                  vld_a_q, vld_a_d;
  logic                  sgn_a_q, sgn_a_d;
  logic [OPS_W-1:0]      opa_q, opa_d;
  logic [OPS_W-1:0]      opw_q, opw_d;
  logic [OUT_W-1:0]      prod_s;
  logic                  vld_b_q, vld_b_d;
  logic [OUT_W-1:0]      prod_q, prod_d;

  // One global enable: every stage moves only when the output slot is free.
  assign en_s     = !out_valid || out_ready;
  assign in_ready = en_s;

  // Stage A next state: capture a beat on enable, otherwise hold.
  always_comb begin
    vld_a_d = vld_a_q;
    sgn_a_d = sgn_a_q;
    opa_d   = opa_q;
    opw_d   = opw_q;
    if (en_s) begin
      vld_a_d = in_valid;
      if (in_valid) begin
        sgn_a_d = sign_mode;
        opa_d   = input_data;
        opw_d   = weight_data;
      end else begin
        sgn_a_d = sgn_a_q;
        opa_d   = opa_q;
        opw_d   = opw_q;
      end
    end else begin
      vld_a_d = vld_a_q;
    end
  end

  // Lane multipliers fed from stage A.
  always_comb begin
    prod_s = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      prod_s[i*PROD_WIDTH +: PROD_WIDTH] =
        ext_operand(opa_q[i*DATA_WIDTH +: DATA_WIDTH], sgn_a_q) *
        ext_operand(opw_q[i*DATA_WIDTH +: DATA_WIDTH], sgn_a_q);
    end
  end

  // Stage B next state: products advance with stage A's valid bit.
  always_comb begin
    vld_b_d = vld_b_q;
    prod_d  = prod_q;
    if (en_s) begin
      vld_b_d = vld_a_q;
      if (vld_a_q) begin
        prod_d = prod_s;
      end else begin
        prod_d = prod_q;
      end
    end else begin
      vld_b_d = vld_b_q;
    end
  end

  // Stage A and B registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_q <= 1'b0;
      sgn_a_q <= 1'b0;
      opa_q   <= '0;
      opw_q   <= '0;
      vld_b_q <= 1'b0;
      prod_q  <= '0;
    end else begin
      vld_a_q <= vld_a_d;
      sgn_a_q <= sgn_a_d;
      opa_q   <= opa_d;
      opw_q   <= opw_d;
      vld_b_q <= vld_b_d;
      prod_q  <= prod_d;
    end
  end

`ifdef MULT_ARRAY_PIPE_SUM_EN
  // Widen a product to SUM_WIDTH following the beat's signedness; the loop
  // form also covers SUM_WIDTH == PROD_WIDTH (single lane).
  function automatic logic [SUM_WIDTH-1:0] ext_sum(input logic [PROD_WIDTH-1:0] p,
                                                   input logic sgn);
    logic [SUM_WIDTH-1:0] r;
    r = '0;
    r[PROD_WIDTH-1:0] = p;
    for (int k = PROD_WIDTH; k < SUM_WIDTH; k++) begin
      r[k] = sgn & p[PROD_WIDTH-1];
    end
    return r;
  endfunction

  logic                 sgn_b_q, sgn_b_d;
  logic                 vld_c_q, vld_c_d;
  logic [OUT_W-1:0]     outd_c_q, outd_c_d;
  logic [SUM_WIDTH-1:0] sum_c_q, sum_c_d;
  logic [SUM_WIDTH-1:0] sum_s;

  // Stage B sign bit travels with the products so the sum extends correctly.
  always_comb begin
    sgn_b_d = sgn_b_q;
    if (en_s && vld_a_q) begin
      sgn_b_d = sgn_a_q;
    end else begin
      sgn_b_d = sgn_b_q;
    end
  end

  // Adder tree over the stage B products.
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      sum_s = sum_s + ext_sum(prod_q[i*PROD_WIDTH +: PROD_WIDTH], sgn_b_q);
    end
  end

  // Stage C next state: sum plus a delayed copy of the products.
  always_comb begin
    vld_c_d  = vld_c_q;
    outd_c_d = outd_c_q;
    sum_c_d  = sum_c_q;
    if (en_s) begin
      vld_c_d = vld_b_q;
      if (vld_b_q) begin
        outd_c_d = prod_q;
        sum_c_d  = sum_s;
      end else begin
        outd_c_d = outd_c_q;
        sum_c_d  = sum_c_q;
      end
    end else begin
      vld_c_d = vld_c_q;
    end
  end

  // Stage B sign and stage C registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn_b_q  <= 1'b0;
      vld_c_q  <= 1'b0;
      outd_c_q <= '0;
      sum_c_q  <= '0;
    end else begin
      sgn_b_q  <= sgn_b_d;
      vld_c_q  <= vld_c_d;
      outd_c_q <= outd_c_d;
      sum_c_q  <= sum_c_d;
    end
  end

  assign out_valid   = vld_c_q;
  assign output_data = outd_c_q;
  assign sum_data    = sum_c_q;
  assign busy        = vld_a_q | vld_b_q | vld_c_q;
`else
  assign out_valid   = vld_b_q;
  assign output_data = prod_q;
  assign sum_data    = '0;
  assign busy        = vld_a_q | vld_b_q;
`endif

endmodule
